cm_unsort: RTL and testbench

- Inverse of the bitonic sort stage: takes a sorted data vector plus its per-element original-position index vector and scatters each element back to its original slot.
- Sits downstream of the sorter, after any processing done in sorted order.
- Restores original ordering for consumers that need it.
- Has a valid/ready handshake, a 2-entry output buffer and a permutation-integrity error flag.

---
 rtl/cm_unsort.sv | 112 +++++++++++
 tb/tb_cm_unsort.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cm_unsort.sv
// cm_unsort: scatters a sorted vector back to its original element order.
// Each element k of i_data goes to slot i_idx[k]. The scattered vector and a
// permutation-integrity error bit are queued in a 2-entry FIFO behind a
// valid/ready handshake. o_data/o_err always present the head entry, or the
// last-popped entry when the FIFO is empty.
module cm_unsort #(
  parameter int DCNT   = 4,
  parameter int DWIDTH = 8,
  localparam int IWIDTH = $clog2(DCNT)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_vld,
  output logic                     o_rdy,
  input  logic [DCNT*IWIDTH-1:0]   i_idx,
  input  logic [DCNT*DWIDTH-1:0]   i_data,
  output logic                     o_vld,
  input  logic                     i_rdy,
  output logic [DCNT*DWIDTH-1:0]   o_data,
  output logic                     o_err
);

  // Element count at index width + 1, so out-of-range indices can be detected
  // when DCNT is not a power of two.
  localparam logic [IWIDTH:0] DCNT_L = (IWIDTH + 1)'(DCNT);

  typedef struct packed {
    logic                   err;
    logic [DCNT*DWIDTH-1:0] data;
  } entry_t;

  logic [DCNT*DWIDTH-1:0] scat_data;
  logic                   scat_err;
  logic [DCNT-1:0]        slot_hit;

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic [1:0] cnt_q, cnt_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       push, pop;
  logic       head_sel;

  // Scatter: walk k in ascending order so the highest colliding k wins a slot.
  // NOTE: every variable written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    scat_data = '0;
    scat_err  = 1'b0;
    slot_hit  = '0;
    for (int s = 0; s < DCNT; s++) begin
      for (int k = 0; k < DCNT; k++) begin
        if (i_idx[k*IWIDTH +: IWIDTH] == IWIDTH'(s)) begin
          if (slot_hit[s]) scat_err = 1'b1;
          slot_hit[s]                   = 1'b1;
          scat_data[s*DWIDTH +: DWIDTH] = i_data[k*DWIDTH +: DWIDTH];
        end
      end
      if (!slot_hit[s]) scat_err = 1'b1;
    end
    // Out-of-range indices never match a slot above, so their data is dropped.
    for (int k = 0; k < DCNT; k++) begin
      if ({1'b0, i_idx[k*IWIDTH +: IWIDTH]} >= DCNT_L) scat_err = 1'b1;
    end
  end

  assign o_rdy = (cnt_q != 2'd2) && !i_rst;
  assign o_vld = (cnt_q != 2'd0);
  assign push  = i_vld && o_rdy;
  assign pop   = o_vld && i_rdy;

  // When empty, the write pointer equals the read pointer, so the other entry
  // still holds the most recently popped vector.
  assign head_sel = (cnt_q == 2'd0) ? ~rd_ptr_q : rd_ptr_q;
  assign o_data   = mem_q[head_sel].data;
  assign o_err    = mem_q[head_sel].err;

  // FIFO next-state: occupancy, pointers and the entry written on push.
  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    mem_d    = mem_q;
    if (push && !pop)      cnt_d = cnt_q + 2'd1;
    else if (pop && !push) cnt_d = cnt_q - 2'd1;
    if (push) begin
      mem_d[wr_ptr_q].data = scat_data;
      mem_d[wr_ptr_q].err  = scat_err;
    end
  end

  // FIFO state registers with synchronous reset.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; the entry storage is reset too, since o_data must read
  // zero after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
    end
  end

endmodule

// File: tb/tb_cm_unsort.sv
// Self-checking bench for cm_unsort: table-driven scatter vectors plus
// hand-written sequences for backpressure, streaming, reset and DCNT=3.
module tb_cm_unsort;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld, rdy_out, rdy_in, ovld, oerr;
  logic [7:0]  idx;
  logic [31:0] data, odata;

  // Second instance with a non-power-of-two element count.
  logic        vld3, rdy3_out, ovld3, oerr3;
  logic [5:0]  idx3;
  logic [23:0] data3, odata3;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cm_unsort #(.DCNT(4), .DWIDTH(8)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_vld(vld), .o_rdy(rdy_out),
    .i_idx(idx), .i_data(data), .o_vld(ovld), .i_rdy(rdy_in),
    .o_data(odata), .o_err(oerr)
  );

  cm_unsort #(.DCNT(3), .DWIDTH(8)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_vld(vld3), .o_rdy(rdy3_out),
    .i_idx(idx3), .i_data(data3), .o_vld(ovld3), .i_rdy(1'b1),
    .o_data(odata3), .o_err(oerr3)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  idx;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [31:0] d4(input logic [7:0] a, b, c, e);
    return {e, c, b, a};   // element 0 in the low byte
  endfunction

  function automatic logic [7:0] i4(input logic [1:0] a, b, c, e);
    return {e, c, b, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{d4(10, 20, 30, 40), i4(2, 0, 3, 1), d4(20, 40, 10, 30), 1'b0};
    tbl[1] = '{d4(5, 6, 7, 8),     i4(1, 1, 2, 3), d4(0, 6, 7, 8),     1'b1};
    tbl[2] = '{d4(8'h11, 8'h22, 8'h33, 8'h44), i4(0, 1, 2, 3),
               d4(8'h11, 8'h22, 8'h33, 8'h44), 1'b0};
    tbl[3] = '{d4(8'hAA, 8'hBB, 8'hCC, 8'hDD), i4(3, 2, 1, 0),
               d4(8'hDD, 8'hCC, 8'hBB, 8'hAA), 1'b0};
    tbl[4] = '{d4(1, 2, 3, 4),     i4(2, 2, 2, 2), d4(0, 0, 4, 0),     1'b1};
    tbl[5] = '{d4(8'hFF, 8'h00, 8'h80, 8'h7F), i4(1, 2, 3, 0),
               d4(8'h7F, 8'hFF, 8'h00, 8'h80), 1'b0};
    tbl[6] = '{d4(9, 8, 7, 6),     i4(0, 3, 0, 3), d4(7, 0, 0, 6),     1'b1};

    rst = 1'b1; vld = 1'b0; rdy_in = 1'b1; idx = '0; data = '0;
    vld3 = 1'b0; idx3 = '0; data3 = '0;

    // Reset state: inputs presented during reset are ignored.
    @(negedge clk); vld = 1'b1; data = 32'hDEADBEEF;
    @(negedge clk);
    check("rst_rdy", 32'(rdy_out), 0);
    check("rst_vld", 32'(ovld), 0);
    check("rst_data", odata, 0);
    check("rst_err", 32'(oerr), 0);
    rst = 1'b0; vld = 1'b0;
    #1 check("rdy_after_rst", 32'(rdy_out), 1);

    // Table-driven scatter vectors, one at a time with i_rdy high.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      vld = 1'b1; data = tbl[i].data; idx = tbl[i].idx;
      @(negedge clk);
      vld = 1'b0;
      check($sformatf("vec%0d_vld", i), 32'(ovld), 1);
      check($sformatf("vec%0d_data", i), odata, tbl[i].exp_data);
      check($sformatf("vec%0d_err", i), 32'(oerr), 32'(tbl[i].exp_err));
    end
    @(negedge clk);
    check("drain_vld", 32'(ovld), 0);
    check("empty_shows_last", odata, tbl[6].exp_data);

    // Backpressure: A, B accepted, C held until space frees up.
    rdy_in = 1'b0;
    vld = 1'b1; data = d4(1, 2, 3, 4); idx = i4(0, 1, 2, 3);
    @(negedge clk);
    check("bp_a_vld", 32'(ovld), 1);
    check("bp_a_data", odata, d4(1, 2, 3, 4));
    data = d4(5, 6, 7, 8); idx = i4(3, 2, 1, 0);
    @(negedge clk);
    check("bp_full_rdy", 32'(rdy_out), 0);
    check("bp_a_hold1", odata, d4(1, 2, 3, 4));
    data = d4(9, 10, 11, 12); idx = i4(1, 0, 3, 2);
    @(negedge clk);
    check("bp_full_rdy2", 32'(rdy_out), 0);
    check("bp_a_hold2", odata, d4(1, 2, 3, 4));
    rdy_in = 1'b1;
    @(negedge clk);
    check("bp_b_data", odata, d4(8, 7, 6, 5));
    check("bp_b_rdy", 32'(rdy_out), 1);
    @(negedge clk);
    check("bp_c_data", odata, d4(10, 9, 12, 11));
    vld = 1'b0;
    @(negedge clk);
    check("bp_empty_vld", 32'(ovld), 0);
    check("bp_empty_last", odata, d4(10, 9, 12, 11));

    // Streaming: 8 vectors back to back, one per cycle, cnt never reaches 2.
    for (int v = 0; v <= 8; v++) begin
      @(negedge clk);
      if (v > 0) begin
        check($sformatf("strm%0d_vld", v - 1), 32'(ovld), 1);
        check($sformatf("strm%0d_rdy", v - 1), 32'(rdy_out), 1);
        check($sformatf("strm%0d_data", v - 1), odata,
              d4(8'(4*v), 8'(4*v - 1), 8'(4*v - 2), 8'(4*v - 3)));
      end
      if (v < 8) begin
        vld = 1'b1; idx = i4(3, 2, 1, 0);
        data = d4(8'(4*v + 1), 8'(4*v + 2), 8'(4*v + 3), 8'(4*v + 4));
      end else begin
        vld = 1'b0;
      end
    end
    @(negedge clk);
    check("strm_end_vld", 32'(ovld), 0);

    // Reset mid-operation with two buffered vectors; head carries err = 1.
    rdy_in = 1'b0;
    vld = 1'b1; data = d4(5, 6, 7, 8); idx = i4(1, 1, 2, 3);
    @(negedge clk);
    data = d4(1, 2, 3, 4); idx = i4(0, 1, 2, 3);
    @(negedge clk);
    vld = 1'b0;
    check("mid_full_rdy", 32'(rdy_out), 0);
    check("mid_head_err", 32'(oerr), 1);
    rst = 1'b1; vld = 1'b1;
    #1 check("mid_rst_rdy", 32'(rdy_out), 0);
    @(negedge clk);
    check("mid_rst_vld", 32'(ovld), 0);
    check("mid_rst_data", odata, 0);
    check("mid_rst_err", 32'(oerr), 0);
    rst = 1'b0; vld = 1'b0; rdy_in = 1'b1;
    #1 check("mid_post_rdy", 32'(rdy_out), 1);
    @(negedge clk);
    check("mid_no_emit", 32'(ovld), 0);

    // DCNT = 3: index 3 is out of range, its element is dropped.
    vld3 = 1'b1; data3 = {8'd3, 8'd2, 8'd1}; idx3 = {2'd0, 2'd3, 2'd2};
    @(negedge clk);
    vld3 = 1'b0;
    check("d3_oor_vld", 32'(ovld3), 1);
    check("d3_oor_data", 32'(odata3), 32'({8'd1, 8'd0, 8'd3}));
    check("d3_oor_err", 32'(oerr3), 1);
    @(negedge clk);
    vld3 = 1'b1; data3 = {8'd6, 8'd5, 8'd4}; idx3 = {2'd1, 2'd0, 2'd2};
    @(negedge clk);
    vld3 = 1'b0;
    check("d3_ok_data", 32'(odata3), 32'({8'd4, 8'd6, 8'd5}));
    check("d3_ok_err", 32'(oerr3), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
